// File: rtl/jbi_dbg_ctl_drain.sv
// JBI debug-port queue drain: pops DBGQ entries, serializes each LSB-first into
// OUT_W-bit beats with valid/ready, tags post-overflow entries and counts entries sent.
module jbi_dbg_ctl_drain #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned OUT_W   = 16,
   parameter int unsigned GAP_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cnt_clr,
   input  logic              q_empty,
   input  logic              q_ovf,
   input  logic [DATA_W-1:0] q_rdata,
   output logic              q_pop,
   output logic              dbg_valid,
   input  logic              dbg_ready,
   output logic [OUT_W-1:0]  dbg_data,
   output logic              dbg_sop,
   output logic              dbg_eop,
   output logic              dbg_ovf,
   output logic              busy,
   output logic [15:0]       entry_cnt
);

   localparam int unsigned   NBEATS    = DATA_W / OUT_W;
   localparam int unsigned   BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
   localparam logic [3:0]    GAP_LAST  = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_t;

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [BW-1:0]     beat_cnt;
   logic [3:0]        gap_cnt;
   logic              accept;

   // Everything below is decoded from registers only, except the pop request,
   // which must react to en/q_empty in the same cycle; it is held off during reset.
   assign q_pop     = ~rst & (state == IDLE) & en & ~q_empty;
   assign dbg_valid = (state == SEND);
   assign dbg_data  = shreg[OUT_W-1:0];
   assign dbg_sop   = dbg_valid & (beat_cnt == '0);
   assign dbg_eop   = dbg_valid & (beat_cnt == LAST_BEAT);
   assign busy      = (state != IDLE);
   assign accept    = dbg_valid & dbg_ready;

   // NOTE: all state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: shreg is a plain register, not a RAM, so it is reset like the rest.
         state     <= IDLE;
         shreg     <= '0;
         beat_cnt  <= '0;
         gap_cnt   <= '0;
         dbg_ovf   <= 1'b0;
         entry_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (q_pop) begin
                  dbg_ovf <= q_ovf;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               shreg    <= q_rdata;
               beat_cnt <= '0;
               state    <= SEND;
            end
            SEND: begin
               if (accept) begin
                  shreg    <= shreg >> OUT_W;
                  beat_cnt <= beat_cnt + 1'b1;
                  if (dbg_eop) begin
                     gap_cnt <= '0;
                     state   <= (GAP_CYC > 0) ? GAP : IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) state <= IDLE;
               else                     gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase

         // Clear wins over a coincident end-of-entry increment.
         if (cnt_clr)
            entry_cnt <= '0;
         else if (accept && dbg_eop && entry_cnt != 16'hFFFF)
            entry_cnt <= entry_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_jbi_dbg_ctl_drain.sv
// Directed bench for jbi_dbg_ctl_drain; a small DBGQ model supplies entries,
// read data appears only in the cycle after a pop.
module tb_jbi_dbg_ctl_drain;

   logic        clk = 1'b0;
   logic        rst, en, cnt_clr, q_empty, q_ovf, q_pop;
   logic [63:0] q_rdata = 64'h0;
   logic        dbg_valid, dbg_ready, dbg_sop, dbg_eop, dbg_ovf, busy;
   logic [15:0] dbg_data, entry_cnt;

   int compared   = 0;
   int mismatched = 0;

   logic [63:0] mem [16];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   always #5 clk = ~clk;

   jbi_dbg_ctl_drain #(.DATA_W(64), .OUT_W(16), .GAP_CYC(2)) dut (
      .clk(clk), .rst(rst), .en(en), .cnt_clr(cnt_clr),
      .q_empty(q_empty), .q_ovf(q_ovf), .q_rdata(q_rdata), .q_pop(q_pop),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_data(dbg_data),
      .dbg_sop(dbg_sop), .dbg_eop(dbg_eop), .dbg_ovf(dbg_ovf),
      .busy(busy), .entry_cnt(entry_cnt)
   );

   // Queue model: synchronous RAM read; garbage on the bus when not popped.
   assign q_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (q_pop) begin
         q_rdata <= mem[rd_ptr[3:0]];
         rd_ptr  <= rd_ptr + 1;
      end else begin
         q_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
      end
   end

   task automatic push(input logic [63:0] val);
      mem[wr_ptr[3:0]] = val;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      compared++; if ({q_pop, dbg_valid, dbg_sop, dbg_eop, dbg_ovf, busy} !== 6'b0) begin
         mismatched++; $display("FAIL reset_ctl: pop/v/sop/eop/ovf/busy=%b want 000000",
            {q_pop, dbg_valid, dbg_sop, dbg_eop, dbg_ovf, busy}); end
      compared++; if (dbg_data !== 16'h0) begin
         mismatched++; $display("FAIL reset_data: got %h want 0000", dbg_data); end
      compared++; if (entry_cnt !== 16'h0) begin
         mismatched++; $display("FAIL reset_cnt: got %h want 0000", entry_cnt); end
      @(negedge clk); rst = 1'b0; #1;
      compared++; if ({busy, q_pop} !== 2'b00) begin
         mismatched++; $display("FAIL reset_idle: busy/pop=%b want 00", {busy, q_pop}); end
   endtask

   task automatic test_single();
      logic [15:0] exp_d [4];
      exp_d = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
      push(64'h1111_2222_3333_4444);
      @(negedge clk); en = 1'b1; dbg_ready = 1'b1; #1;
      compared++; if (q_pop !== 1'b1) begin
         mismatched++; $display("FAIL single_pop: q_pop=%b want 1", q_pop); end
      @(negedge clk); #1;
      compared++; if ({dbg_valid, busy, q_pop} !== 3'b010) begin
         mismatched++; $display("FAIL single_fetch: valid/busy/pop=%b want 010",
            {dbg_valid, busy, q_pop}); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         compared++; if ({dbg_valid, dbg_sop, dbg_eop, dbg_data} !== {1'b1, i == 0, i == 3, exp_d[i]}) begin
            mismatched++; $display("FAIL single_beat%0d: v/sop/eop/data=%b/%b/%b/%h want 1/%b/%b/%h",
               i, dbg_valid, dbg_sop, dbg_eop, dbg_data, i == 0, i == 3, exp_d[i]); end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         compared++; if ({dbg_valid, busy} !== 2'b01) begin
            mismatched++; $display("FAIL single_gap%0d: valid/busy=%b want 01", i, {dbg_valid, busy}); end
      end
      @(negedge clk); en = 1'b0; #1;
      compared++; if ({busy, entry_cnt} !== {1'b0, 16'd1}) begin
         mismatched++; $display("FAIL single_done: busy=%b cnt=%0d want busy=0 cnt=1", busy, entry_cnt); end
   endtask

   task automatic test_backpressure();
      logic        rdy   [7];
      logic [15:0] exp_d [7];
      int          beats = 0;
      rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_d = '{16'h6666, 16'h3333, 16'h3333, 16'h3333, 16'h3333, 16'h5555, 16'h4444};
      push(64'h4444_5555_3333_6666);
      @(negedge clk); en = 1'b1; dbg_ready = 1'b1; #1;
      compared++; if (q_pop !== 1'b1) begin
         mismatched++; $display("FAIL bp_pop: q_pop=%b want 1", q_pop); end
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); dbg_ready = rdy[i]; #1;
         compared++; if ({dbg_valid, dbg_data} !== {1'b1, exp_d[i]}) begin
            mismatched++; $display("FAIL bp_cycle%0d: valid/data=%b/%h want 1/%h",
               i, dbg_valid, dbg_data, exp_d[i]); end
         if (dbg_valid && dbg_ready) beats++;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         if (dbg_valid && dbg_ready) beats++;
      end
      @(negedge clk); en = 1'b0; #1;
      compared++; if (beats !== 4) begin
         mismatched++; $display("FAIL bp_beats: accepted %0d want 4", beats); end
      compared++; if ({busy, entry_cnt} !== {1'b0, 16'd2}) begin
         mismatched++; $display("FAIL bp_done: busy=%b cnt=%0d want busy=0 cnt=2", busy, entry_cnt); end
   endtask

   task automatic test_ovf();
      logic [15:0] exp_a [4];
      logic [15:0] exp_b [4];
      exp_a = '{16'hA003, 16'hA002, 16'hA001, 16'hA000};
      exp_b = '{16'hB003, 16'hB002, 16'hB001, 16'hB000};
      push(64'hA000_A001_A002_A003);
      push(64'hB000_B001_B002_B003);
      @(negedge clk); en = 1'b1; q_ovf = 1'b1; #1;
      compared++; if (q_pop !== 1'b1) begin
         mismatched++; $display("FAIL ovf_pop_a: q_pop=%b want 1", q_pop); end
      @(negedge clk); q_ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         compared++; if ({dbg_ovf, dbg_data} !== {1'b1, exp_a[i]}) begin
            mismatched++; $display("FAIL ovf_a_beat%0d: ovf/data=%b/%h want 1/%h", i, dbg_ovf, dbg_data, exp_a[i]); end
      end
      @(negedge clk); #1;
      compared++; if (q_pop !== 1'b0) begin
         mismatched++; $display("FAIL ovf_gap_pop: q_pop=%b want 0", q_pop); end
      @(negedge clk);
      @(negedge clk); #1;
      compared++; if (q_pop !== 1'b1) begin
         mismatched++; $display("FAIL ovf_pop_b: q_pop=%b want 1 (8-cycle spacing)", q_pop); end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); en = 1'b0; #1;
         compared++; if ({dbg_ovf, dbg_data} !== {1'b0, exp_b[i]}) begin
            mismatched++; $display("FAIL ovf_b_beat%0d: ovf/data=%b/%h want 0/%h", i, dbg_ovf, dbg_data, exp_b[i]); end
      end
      repeat (3) @(negedge clk);
      #1;
      compared++; if ({busy, entry_cnt} !== {1'b0, 16'd4}) begin
         mismatched++; $display("FAIL ovf_done: busy=%b cnt=%0d want busy=0 cnt=4", busy, entry_cnt); end
   endtask

   task automatic test_enable_drop();
      logic [15:0] exp_c [4];
      logic [15:0] exp_e [4];
      exp_c = '{16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3};
      exp_e = '{16'hD0D0, 16'hD1D1, 16'hD2D2, 16'hD3D3};
      push(64'hC3C3_C2C2_C1C1_C0C0);
      push(64'hD3D3_D2D2_D1D1_D0D0);
      @(negedge clk); en = 1'b1; #1;
      compared++; if (q_pop !== 1'b1) begin
         mismatched++; $display("FAIL en_pop_c: q_pop=%b want 1", q_pop); end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); en = 1'b0; #1;
         compared++; if ({dbg_valid, dbg_data} !== {1'b1, exp_c[i]}) begin
            mismatched++; $display("FAIL en_c_beat%0d: valid/data=%b/%h want 1/%h", i, dbg_valid, dbg_data, exp_c[i]); end
      end
      @(negedge clk);
      @(negedge clk); #1;
      compared++; if (busy !== 1'b1) begin
         mismatched++; $display("FAIL en_gap_busy: busy=%b want 1", busy); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         compared++; if ({busy, q_pop} !== 2'b00) begin
            mismatched++; $display("FAIL en_off_idle%0d: busy/pop=%b want 00", i, {busy, q_pop}); end
      end
      @(negedge clk); en = 1'b1; #1;
      compared++; if (q_pop !== 1'b1) begin
         mismatched++; $display("FAIL en_pop_d: q_pop=%b want 1", q_pop); end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); en = 1'b0; #1;
         compared++; if (dbg_data !== exp_e[i]) begin
            mismatched++; $display("FAIL en_d_beat%0d: data=%h want %h", i, dbg_data, exp_e[i]); end
      end
      repeat (3) @(negedge clk);
      #1;
      compared++; if ({busy, entry_cnt} !== {1'b0, 16'd6}) begin
         mismatched++; $display("FAIL en_done: busy=%b cnt=%0d want busy=0 cnt=6", busy, entry_cnt); end
   endtask

   task automatic test_counter();
      push(64'hE003_E002_E001_E000);
      push(64'hE103_E102_E101_E100);
      push(64'hE203_E202_E201_E200);
      @(negedge clk);
      force dut.entry_cnt = 16'hFFFE;
      #1;
      release dut.entry_cnt;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (c == 0)  en = 1'b1;
         if (c == 17) en = 1'b0;
         cnt_clr = (c == 21);
         #1;
         if (c == 6) begin
            compared++; if (entry_cnt !== 16'hFFFF) begin
               mismatched++; $display("FAIL cnt_reach_max: got %h want FFFF", entry_cnt); end
         end
         if (c == 14) begin
            compared++; if (entry_cnt !== 16'hFFFF) begin
               mismatched++; $display("FAIL cnt_saturate: got %h want FFFF", entry_cnt); end
         end
         if (c == 21) begin
            compared++; if ({dbg_eop, entry_cnt} !== {1'b1, 16'hFFFF}) begin
               mismatched++; $display("FAIL cnt_eop_align: eop=%b cnt=%h want 1/FFFF", dbg_eop, entry_cnt); end
         end
         if (c == 22) begin
            compared++; if (entry_cnt !== 16'h0) begin
               mismatched++; $display("FAIL cnt_clr_wins: got %h want 0000", entry_cnt); end
         end
         if (c == 24) begin
            compared++; if ({busy, q_pop} !== 2'b00) begin
               mismatched++; $display("FAIL cnt_idle: busy/pop=%b want 00", {busy, q_pop}); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] exp_r [4];
      exp_r = '{16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h9999};
      push(64'h5555_6666_7777_8888);
      push(64'h9999_AAAA_BBBB_CCCC);
      @(negedge clk); en = 1'b1; #1;
      compared++; if (q_pop !== 1'b1) begin
         mismatched++; $display("FAIL rst_pop_first: q_pop=%b want 1", q_pop); end
      repeat (3) @(negedge clk);
      #1;
      compared++; if (dbg_data !== 16'h7777) begin
         mismatched++; $display("FAIL rst_beat2: data=%h want 7777", dbg_data); end
      #2 rst = 1'b1;
      #1;
      compared++; if ({q_pop, dbg_valid, dbg_sop, dbg_eop, dbg_ovf, busy, dbg_data, entry_cnt} !== 38'b0) begin
         mismatched++; $display("FAIL rst_async: pop/v/sop/eop/ovf/busy=%b data=%h cnt=%h want all 0",
            {q_pop, dbg_valid, dbg_sop, dbg_eop, dbg_ovf, busy}, dbg_data, entry_cnt); end
      @(negedge clk); rst = 1'b0; #1;
      compared++; if (q_pop !== 1'b1) begin
         mismatched++; $display("FAIL rst_pop_next: q_pop=%b want 1", q_pop); end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); en = 1'b0; #1;
         compared++; if ({dbg_valid, dbg_sop, dbg_data} !== {1'b1, i == 0, exp_r[i]}) begin
            mismatched++; $display("FAIL rst_new_beat%0d: v/sop/data=%b/%b/%h want 1/%b/%h",
               i, dbg_valid, dbg_sop, dbg_data, i == 0, exp_r[i]); end
      end
      repeat (3) @(negedge clk);
      #1;
      compared++; if ({busy, entry_cnt} !== {1'b0, 16'd1}) begin
         mismatched++; $display("FAIL rst_done: busy=%b cnt=%0d want busy=0 cnt=1", busy, entry_cnt); end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; cnt_clr = 1'b0; q_ovf = 1'b0; dbg_ready = 1'b1;
      test_reset();
      test_single();
      test_backpressure();
      test_ovf();
      test_enable_drop();
      test_counter();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
